// File: rtl/adder_flt_pkg.sv
// Shared types and constants for the adder fault locator.
// FSM states, vector-index field offsets, saturation limit.
package adder_flt_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      WAIT,
      CHECK,
      DONE
   } state_t;

   localparam int VEC_C     = 0;
   localparam int VEC_B     = 1;
   localparam int VEC_A     = 2;
   localparam int VEC_SLICE = 3;

   localparam logic [7:0] FAIL_CNT_MAX = 8'd255;

endpackage

// File: rtl/adder_vec_gen.sv
// Combinational vector index -> {a, b, cin, expected sum, target slice}.
// Slice i sees a_i, b_i and a carry-in c forced through the lower slices.
module adder_vec_gen
   import adder_flt_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [7:0]       vec,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             cin,
   output logic [WIDTH:0]   expected,
   output logic [7:0]       slice
);

   logic [7:0] tgt;

   assign tgt   = vec >> VEC_SLICE;
   assign slice = tgt;

   // c=1 on slice i>0: lower a all ones plus cin ripples a carry into i
   always_comb begin
      a   = '0;
      b   = '0;
      cin = vec[VEC_C];
      for (int i = 0; i < WIDTH; i++) begin
         if (8'(i) == tgt) begin
            a[i] = vec[VEC_A];
            b[i] = vec[VEC_B];
         end else if (8'(i) < tgt) begin
            a[i] = vec[VEC_C];
         end
      end
   end

   assign expected = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/adder_fault_locator.sv
// Self-test engine for a WIDTH-bit ripple-carry adder; localizes faulty slices.
// Optional first-failure log enabled by defining FAULT_LOG_EN.
module adder_fault_locator
   import adder_flt_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] dut_a,
   output logic [WIDTH-1:0] dut_b,
   output logic             dut_cin,
   input  logic [WIDTH:0]   dut_sum,
   output logic [WIDTH-1:0] fault_mask,
   output logic [7:0]       fail_count,
   output logic             log_valid,
   output logic [7:0]       log_vec,
   output logic [WIDTH:0]   log_sum
);

   localparam logic [7:0] VEC_LAST = 8'(8 * WIDTH - 1);
   localparam logic [7:0] WAIT_END = 8'(SETTLE - 1);

   state_t           state, state_nx;
   logic [7:0]       vec;
   logic [7:0]       wcnt;
   logic [WIDTH-1:0] gen_a, gen_b;
   logic             gen_cin;
   logic [WIDTH:0]   gen_exp;
   logic [7:0]       gen_slice;
   logic             mismatch;
   logic             run_start;

   adder_vec_gen #(.WIDTH(WIDTH)) u_gen (
      .vec      (vec),
      .a        (gen_a),
      .b        (gen_b),
      .cin      (gen_cin),
      .expected (gen_exp),
      .slice    (gen_slice)
   );

   assign mismatch  = (state == CHECK) && (dut_sum != gen_exp);
   assign run_start = (state == IDLE) && start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (start) state_nx = DRIVE;
         DRIVE: state_nx = WAIT;
         WAIT:  if (wcnt == WAIT_END) state_nx = CHECK;
         CHECK: state_nx = (vec == VEC_LAST) ? DONE : DRIVE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         vec        <= '0;
         wcnt       <= '0;
         dut_a      <= '0;
         dut_b      <= '0;
         dut_cin    <= 1'b0;
         fault_mask <= '0;
         fail_count <= '0;
      end else begin
         // status trails the state by one cycle so busy and done never overlap
         busy <= (state == DRIVE) || (state == WAIT) || (state == CHECK);
         done <= (state == DONE);
         unique case (state)
            IDLE: begin
               if (start) begin
                  vec        <= '0;
                  pass       <= 1'b0;
                  fault_mask <= '0;
                  fail_count <= '0;
               end
            end
            DRIVE: begin
               dut_a   <= gen_a;
               dut_b   <= gen_b;
               dut_cin <= gen_cin;
               wcnt    <= '0;
            end
            WAIT: wcnt <= wcnt + 8'd1;
            CHECK: begin
               if (mismatch) begin
                  fault_mask <= fault_mask | (WIDTH'(1) << gen_slice);
                  if (fail_count != FAIL_CNT_MAX)
                     fail_count <= fail_count + 8'd1;
               end
               if (vec != VEC_LAST) vec <= vec + 8'd1;
            end
            DONE: pass <= (fail_count == 8'd0);
            default: ;
         endcase
      end
   end

`ifdef FAULT_LOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         log_valid <= 1'b0;
         log_vec   <= '0;
         log_sum   <= '0;
      end else if (run_start) begin
         log_valid <= 1'b0;
         log_vec   <= '0;
         log_sum   <= '0;
      end else if (mismatch && !log_valid) begin
         log_valid <= 1'b1;
         log_vec   <= vec;
         log_sum   <= dut_sum;
      end
   end
`else
   logic unused_log;
   assign unused_log = run_start;
   assign log_valid  = 1'b0;
   assign log_vec    = '0;
   assign log_sum    = '0;
`endif

endmodule

// File: tb/tb_adder_fault_locator.sv
// Directed bench: faulty/golden adder models around two locator instances.
// Second instance uses SETTLE=4 against a 3-cycle delayed adder.
module tb_adder_fault_locator;

   logic       clk = 1'b0;
   logic       rst_n;
   int         fault_mode;
   int         n_chk = 0;
   int         n_fail = 0;

   logic       start, busy, done, pass;
   logic [7:0] dut_a, dut_b, fault_mask, fail_count, log_vec;
   logic       dut_cin, log_valid;
   logic [8:0] dut_sum, log_sum;

   logic       start4, busy4, done4, pass4;
   logic [7:0] dut_a4, dut_b4, fault_mask4, fail_count4, log_vec4;
   logic       dut_cin4, log_valid4;
   logic [8:0] dut_sum4, log_sum4, d1, d2;

   always #5 clk = ~clk;

   adder_fault_locator #(.WIDTH(8), .SETTLE(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .busy(busy), .done(done), .pass(pass),
      .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
      .dut_sum(dut_sum), .fault_mask(fault_mask),
      .fail_count(fail_count), .log_valid(log_valid),
      .log_vec(log_vec), .log_sum(log_sum)
   );

   adder_fault_locator #(.WIDTH(8), .SETTLE(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4),
      .busy(busy4), .done(done4), .pass(pass4),
      .dut_a(dut_a4), .dut_b(dut_b4), .dut_cin(dut_cin4),
      .dut_sum(dut_sum4), .fault_mask(fault_mask4),
      .fail_count(fail_count4), .log_valid(log_valid4),
      .log_vec(log_vec4), .log_sum(log_sum4)
   );

   // ripple-carry adder under test; mode 1/2 plant slice faults
   function automatic logic [8:0] fa_chain(
      input logic [7:0] a, input logic [7:0] b,
      input logic ci, input int mode);
      logic c, s, co;
      logic [8:0] r;
      c = ci;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         s  = a[i] ^ b[i] ^ c;
         co = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
         if (mode == 1 && i == 5 && a[i] && b[i] && !c) s = ~s;
         if (mode == 2 && i == 0) co = 1'b0;
         r[i] = s;
         c = co;
      end
      r[8] = c;
      return r;
   endfunction

   always_comb dut_sum = fa_chain(dut_a, dut_b, dut_cin, fault_mode);

   always @(posedge clk) begin
      d1       <= fa_chain(dut_a4, dut_b4, dut_cin4, 0);
      d2       <= d1;
      dut_sum4 <= d2;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_log(input logic v, input logic [7:0] lv,
                            input logic [8:0] ls);
`ifdef FAULT_LOG_EN
      check("log_valid", 32'(log_valid), 32'(v));
      check("log_vec", 32'(log_vec), 32'(lv));
      check("log_sum", 32'(log_sum), 32'(ls));
`else
      check("log_valid", 32'(log_valid), 32'(1'b0));
      check("log_vec", 32'(log_vec), 32'(8'd0));
      check("log_sum", 32'(log_sum), 32'(9'd0));
      if (v && lv == 8'hff && ls == 9'h1ff) $display("unused");
`endif
   endtask

   task automatic run(input bit sel, input int stray_at,
                      output int done_cyc, output int pulses,
                      output bit ovl, output bit busy1);
      int cyc;
      if (sel) start4 = 1'b1;
      else     start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; start4 = 1'b0;
      cyc = 0; done_cyc = -1; pulses = 0; ovl = 0; busy1 = 0;
      while (cyc < 600 && !(done_cyc >= 0 && cyc >= done_cyc + 4)) begin
         if (cyc == stray_at) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
         if (cyc == 1) busy1 = sel ? busy4 : busy;
         if (sel ? done4 : done) begin
            pulses++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (sel ? (busy4 && done4) : (busy && done)) ovl = 1;
      end
   endtask

   task automatic run_main(input string tag, input int stray_at);
      int dc, np;
      bit ov, b1;
      run(1'b0, stray_at, dc, np, ov, b1);
      check({tag, "_done_cyc"}, 32'(dc), 32'd257);
      check({tag, "_pulses"}, 32'(np), 32'd1);
      check({tag, "_busy1"}, 32'(b1), 32'd1);
      check({tag, "_overlap"}, 32'(ov), 32'd0);
   endtask

   initial begin
      int dc, np;
      bit ov, b1, seen;
      rst_n = 1'b0; start = 1'b0; start4 = 1'b0; fault_mode = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctl", {29'd0, busy, done, pass}, 32'd0);
      check("rst_dut", {15'd0, dut_a, dut_b, dut_cin}, 32'd0);
      check("rst_res", {16'd0, fault_mask, fail_count}, 32'd0);
      check("rst_ctl4", {29'd0, busy4, done4, pass4}, 32'd0);
      check_log(1'b0, 8'd0, 9'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // golden adder
      fault_mode = 0;
      run_main("gold", -1);
      check("gold_pass", 32'(pass), 32'd1);
      check("gold_mask", 32'(fault_mask), 32'h00);
      check("gold_cnt", 32'(fail_count), 32'd0);
      check_log(1'b0, 8'd0, 9'd0);

      // slice 5 inverts sum on a=1,b=1,cin=0
      fault_mode = 1;
      run_main("s5", -1);
      check("s5_pass", 32'(pass), 32'd0);
      check("s5_mask", 32'(fault_mask), 32'h20);
      check("s5_cnt", 32'(fail_count), 32'd1);
      check_log(1'b1, 8'd46, 9'd96);

      // slice 0 cout stuck-at-0: 4 slice-0 vectors + 4 per c=1 slice 1..7
      fault_mode = 2;
      run_main("s0", -1);
      check("s0_pass", 32'(pass), 32'd0);
      check("s0_mask", 32'(fault_mask), 32'hff);
      check("s0_cnt", 32'(fail_count), 32'd32);
      check_log(1'b1, 8'd3, 9'd0);

      // stray start pulse during vector 10
      fault_mode = 0;
      run_main("stray", 41);
      check("stray_pass", 32'(pass), 32'd1);
      check("stray_cnt", 32'(fail_count), 32'd0);

      // reset at vector 30 aborts the run
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (121) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_ctl", {29'd0, busy, done, pass}, 32'd0);
      check("abort_dut", {15'd0, dut_a, dut_b, dut_cin}, 32'd0);
      check("abort_res", {16'd0, fault_mask, fail_count}, 32'd0);
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         seen |= done;
      end
      rst_n = 1'b1;
      repeat (300) begin
         @(posedge clk); #1;
         seen |= done | busy;
      end
      check("abort_no_done", 32'(seen), 32'd0);
      run_main("restart", -1);
      check("restart_pass", 32'(pass), 32'd1);

      // SETTLE=4 against a 3-cycle delayed golden adder
      run(1'b1, -1, dc, np, ov, b1);
      check("s4_done_cyc", 32'(dc), 32'd385);
      check("s4_pulses", 32'(np), 32'd1);
      check("s4_overlap", 32'(ov), 32'd0);
      check("s4_pass", 32'(pass4), 32'd1);
      check("s4_mask", 32'(fault_mask4), 32'h00);
      check("s4_cnt", 32'(fail_count4), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
